// File: rtl/ps2_keyboard_pkg.sv
// Shared constants, field positions, state encodings and helpers for the
// PS/2 keyboard receiver and its event FIFO.
package ps2_keyboard_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Field positions inside the 16-bit data word
  localparam int DATA_VALID_BIT = 15;
  localparam int DATA_OVF_BIT   = 14;
  localparam int DATA_EXT_BIT   = 9;
  localparam int DATA_BRK_BIT   = 8;
  localparam int DATA_CODE_MSB  = 7;
  localparam int DATA_CODE_LSB  = 0;

  localparam int EVENT_W = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef struct packed {
    logic       extended;
    logic       brk;
    logic [7:0] scancode;
  } ps2_event_t;

  // True when eight data bits plus the parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Power-of-two event FIFO with head-of-queue output; a pop on an empty
// FIFO is ignored and a push on a full FIFO is accepted only alongside a pop.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == CW'(0));
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push & (~full_s | do_pop_s);

  assign full  = full_s;
  assign empty = empty_s;
  assign head  = mem_r[rd_ptr_r];

  // Storage array; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes bytes,
// folds E0/F0 prefixes into events and queues them for a memory-mapped read.
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        ren,
  output logic [15:0] data
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic          clk_meta_r;
  logic          clk_sync_r;
  logic          clk_prev_r;
  logic          data_meta_r;
  logic          data_sync_r;
  logic          fall_s;

  logic [1:0]    state_r;
  logic [3:0]    bit_cnt_r;
  logic [9:0]    shift_r;
  logic [TW-1:0] tmo_r;
  logic          accept_r;
  logic [7:0]    byte_r;

  logic          pend_ext_r;
  logic          pend_brk_r;
  logic          ovf_r;

  logic          is_ext_s;
  logic          is_brk_s;
  logic          push_s;
  logic          ovf_set_s;
  ps2_event_t    event_s;
  logic [EVENT_W-1:0] head_s;
  logic          full_s;
  logic          empty_s;

  // Two-flop synchronizers plus one history flop for edge detection; idle high
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  assign fall_s = clk_prev_r & ~clk_sync_r;

  // Receiver FSM: start bit, 8 data bits LSB first, parity, stop, then check
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 10'd0;
      tmo_r     <= TW'(0);
      accept_r  <= 1'b0;
      byte_r    <= 8'd0;
    end else begin
      accept_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (fall_s && !data_sync_r) begin
            state_r   <= ST_SHIFT;
            bit_cnt_r <= 4'd0;
            tmo_r     <= TW'(0);
          end
        end
        ST_SHIFT: begin
          if (fall_s) begin
            shift_r <= {data_sync_r, shift_r[9:1]};
            tmo_r   <= TW'(0);
            if (bit_cnt_r == 4'd9) begin
              state_r   <= ST_CHECK;
              bit_cnt_r <= 4'd0;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else if (tmo_r == TW'(TIMEOUT - 1)) begin
            // Line went quiet mid-frame: drop what was collected
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            tmo_r     <= TW'(0);
          end else begin
            tmo_r <= tmo_r + TW'(1);
          end
        end
        ST_CHECK: begin
          accept_r <= odd_parity_ok(shift_r[8:0]) & shift_r[9];
          byte_r   <= shift_r[7:0];
          state_r  <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= 4'd0;
          tmo_r     <= TW'(0);
        end
      endcase
    end
  end

  assign is_ext_s  = accept_r && (byte_r == PS2_PREFIX_EXT);
  assign is_brk_s  = accept_r && (byte_r == PS2_PREFIX_BRK);
  assign push_s    = accept_r && !is_ext_s && !is_brk_s;
  assign ovf_set_s = push_s && full_s && !ren;

  assign event_s.extended = pend_ext_r;
  assign event_s.brk      = pend_brk_r;
  assign event_s.scancode = byte_r;

  // Prefix flags accumulate until a non-prefix byte consumes them
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_ext_r <= 1'b0;
      pend_brk_r <= 1'b0;
    end else if (push_s) begin
      pend_ext_r <= 1'b0;
      pend_brk_r <= 1'b0;
    end else begin
      if (is_ext_s) begin
        pend_ext_r <= 1'b1;
      end
      if (is_brk_s) begin
        pend_brk_r <= 1'b1;
      end
    end
  end

  // Sticky overflow; a new drop outranks the clearing read in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ren) begin
      ovf_r <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (ren),
    .din   (event_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Read word assembled from FIFO head and overflow flag
  always_comb begin
    data               = 16'h0000;
    data[DATA_OVF_BIT] = ovf_r;
    if (!empty_s) begin
      data[DATA_VALID_BIT]               = 1'b1;
      data[DATA_EXT_BIT:DATA_CODE_LSB]   = head_s;
    end else begin
      data[DATA_VALID_BIT] = 1'b0;
    end
  end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter DEPTH, default 8: event FIFO entries, power of two, 2..64.
REQ-002 Parameter TIMEOUT, default 50000: clk cycles without a ps2 falling edge before an in-progress frame is aborted.
REQ-003 clk  input  1  system clock; the only clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-006 ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-007 ren  input  1  read strobe from memory map; pops the head entry when FIFO non-empty.
REQ-008 data  output  16  {valid, overflow, 4'b0, extended, break, scancode[7:0]} for the head entry; all zero when empty except overflow.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a falling edge is synchronized ps2_clk 1 then 0 on consecutive cycles.
REQ-010 Receiver FSM SHALL have states IDLE, SHIFT, CHECK; IDLE -> SHIFT on a falling edge with sampled data 0 (start bit); falling edge with data 1 in IDLE is ignored.
REQ-011 SHIFT SHALL sample data on each falling edge, LSB first: 8 data bits, then parity, then stop; after the stop bit -> CHECK.
REQ-012 CHECK (one cycle) SHALL accept the byte only if odd parity over data+parity holds and stop bit is 1; then -> IDLE either way.
REQ-013 In SHIFT, a counter SHALL reload on every falling edge; reaching TIMEOUT SHALL discard the partial frame and return to IDLE.
REQ-014 Decoder: byte 0xE0 SHALL set pending-extended, byte 0xF0 SHALL set pending-break, neither pushes an event.
REQ-015 Any other accepted byte SHALL push {extended=pending-extended, break=pending-break, scancode=byte}, then clear both pending flags in the same cycle.
REQ-016 Push SHALL occur in the cycle after CHECK accepts; entry visible on data the cycle after the push.
REQ-017 data SHALL be combinational from FIFO head and overflow flag; valid = FIFO non-empty.
REQ-018 ren while non-empty SHALL pop at the clock edge; ren while empty SHALL have no effect on FIFO contents.
REQ-019 Push while full and no pop SHALL drop the new event and set overflow.
REQ-020 Simultaneous push and pop while full SHALL perform both, no overflow; while empty, push wins and pop is ignored.
REQ-021 overflow SHALL be sticky and clear on the first ren after it is set, empty or not; a set in the same cycle as that ren takes priority.
REQ-022 FIFO read/write pointers SHALL wrap modulo DEPTH; count width log2(DEPTH)+1.

Reset
REQ-023 reset SHALL force FSM to IDLE, clear bit counter, shift register, timeout counter, pending flags, FIFO pointers/count and overflow; data = 16'h0000 the cycle after reset.
REQ-024 reset asserted mid-frame SHALL discard the frame; the remainder of that frame SHALL NOT produce an event (next edges seen as data bits with value 1 are ignored in IDLE, else a framing/parity error drops it).
REQ-025 Synchronizer flops SHALL reset to 1 (PS/2 idle level).

Structure
REQ-026 Shared package/include SHALL hold PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BRK=8'hF0, bit positions of data fields, FSM state encodings.
REQ-027 The FIFO SHALL be sub-module ps2_event_fifo (width 10, DEPTH param, push/pop/full/empty/head); receiver FSM and decoder stay in ps2_keyboard.

Verification
REQ-028 Frame 0x1C, correct parity, then ren -> data = 16'h801C before ren, 16'h0000 after.
REQ-029 Frames E0,F0,75 -> single event, data = 16'h8375; no events for the prefixes.
REQ-030 Frame 0x1C with parity bit inverted -> no event, data stays 16'h0000; next valid frame 0x32 -> 16'h8032.
REQ-031 Nine frames 0x16..0x1E with DEPTH=8, no reads -> ninth dropped, data = 16'hC016; after one ren data = 16'h8017; eight reads total empty the FIFO with last 16'h801D.
REQ-032 Start bit plus 4 data bits, then silence > TIMEOUT, then full frame 0x29 -> only 16'h8029 produced.
REQ-033 reset asserted at data bit 5 of frame 0x1C, frame completes, then frame 0x24 -> data = 16'h8024 only; simultaneous push+ren on full FIFO -> count unchanged, overflow 0.
